// File: rtl/weight_bank.sv
// weight_bank: row-addressed store of signed fixed-point weights for a small
// layered network, with whole-row write, gradient update and registered read.
//
// State table:
//   IDLE  | normal operation; write, update and read ports are open
//   CLEAR | zeroing one row per cycle, layer-major; all request ports closed
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   clear_req / busy           start a zero sweep / sweep in progress
//   wr_valid/wr_ready          row write handshake (wr_layer, wr_row, wr_data)
//   upd_valid/upd_ready        gradient update handshake (upd_layer, upd_row, dc_dw)
//   rd_valid                   read request (rd_layer, rd_row); result on w/w_valid
//   sat_flag                   sticky: an update saturated
//   addr_err                   sticky: an accepted request was out of range
// Row packing: word 0 sits in the most significant DATA_SIZE bits.

module weight_bank #(
    parameter int DATA_SIZE  = 16,
    parameter int FRAC_BITS  = 8,
    parameter int SIZE       = 3,
    parameter int ROWS       = 3,
    parameter int LAYER_SIZE = 5,
    parameter int LR_SHIFT   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_req,
    output logic                      busy,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [31:0]               wr_layer,
    input  logic [31:0]               wr_row,
    input  logic [DATA_SIZE*SIZE-1:0] wr_data,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [31:0]               upd_layer,
    input  logic [31:0]               upd_row,
    input  logic [DATA_SIZE*SIZE-1:0] dc_dw,
    input  logic                      rd_valid,
    input  logic [31:0]               rd_layer,
    input  logic [31:0]               rd_row,
    output logic [DATA_SIZE*SIZE-1:0] w,
    output logic                      w_valid,
    output logic                      sat_flag,
    output logic                      addr_err
);

    localparam int DEPTH = LAYER_SIZE * ROWS;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ROW_W = DATA_SIZE * SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    // The binary point position does not change the arithmetic; it only has
    // to lie inside the word.
    if (FRAC_BITS >= DATA_SIZE) begin : g_bad_frac
        $error("weight_bank: FRAC_BITS must be smaller than DATA_SIZE");
    end

    logic [0:0]       state;
    logic [IDX_W-1:0] clr_idx;
    logic [ROW_W-1:0] mem [DEPTH];

    function automatic logic [IDX_W-1:0] lin_idx(input logic [31:0] layer,
                                                 input logic [31:0] row);
        return IDX_W'(layer * ROWS + row);
    endfunction

    logic             idle;
    logic             wr_acc, upd_acc, rd_acc;
    logic             wr_ok, upd_ok, rd_ok;
    logic [IDX_W-1:0] wr_idx, upd_idx, rd_idx;

    assign idle      = (state == S_IDLE);
    assign busy      = (state == S_CLEAR);
    assign wr_ready  = idle;
    assign upd_ready = idle & ~wr_valid;

    assign wr_acc  = wr_valid & wr_ready;
    assign upd_acc = upd_valid & upd_ready;
    assign rd_acc  = rd_valid & idle;

    assign wr_ok  = (wr_layer < LAYER_SIZE) && (wr_row < ROWS);
    assign upd_ok = (upd_layer < LAYER_SIZE) && (upd_row < ROWS);
    assign rd_ok  = (rd_layer < LAYER_SIZE) && (rd_row < ROWS);

    assign wr_idx  = lin_idx(wr_layer, wr_row);
    assign upd_idx = lin_idx(upd_layer, upd_row);
    assign rd_idx  = lin_idx(rd_layer, rd_row);

    // Gradient step: one extra bit of headroom holds any difference of two
    // in-range words exactly, so overflow shows up as the top two bits disagreeing.
    logic [ROW_W-1:0]            upd_cur;
    logic [ROW_W-1:0]            upd_next;
    logic                        upd_sat;
    logic [DATA_SIZE-1:0]        cur_word, grad_word;
    logic signed [DATA_SIZE:0]   cur_x, grad_x, diff;

    always_comb begin
        upd_cur   = upd_ok ? mem[upd_idx] : '0;
        upd_next  = '0;
        upd_sat   = 1'b0;
        cur_word  = '0;
        grad_word = '0;
        cur_x     = '0;
        grad_x    = '0;
        diff      = '0;
        for (int i = 0; i < SIZE; i++) begin
            cur_word  = upd_cur[(SIZE-1-i)*DATA_SIZE +: DATA_SIZE];
            grad_word = dc_dw[(SIZE-1-i)*DATA_SIZE +: DATA_SIZE];
            cur_x     = {cur_word[DATA_SIZE-1], cur_word};
            grad_x    = {grad_word[DATA_SIZE-1], grad_word};
            diff      = cur_x - (grad_x >>> LR_SHIFT);
            if (diff[DATA_SIZE] != diff[DATA_SIZE-1]) begin
                upd_sat = 1'b1;
                upd_next[(SIZE-1-i)*DATA_SIZE +: DATA_SIZE] =
                    diff[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                    : {1'b0, {(DATA_SIZE-1){1'b1}}};
            end else begin
                upd_next[(SIZE-1-i)*DATA_SIZE +: DATA_SIZE] = diff[DATA_SIZE-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        state   <= S_CLEAR;
                        clr_idx <= '0;
                    end
                end
                S_CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state <= S_IDLE;
                    end else begin
                        clr_idx <= clr_idx + IDX_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage is not reset directly; the sweep that reset starts zeroes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_CLEAR) begin
                mem[clr_idx] <= '0;
            end else begin
                if (wr_acc && wr_ok) begin
                    mem[wr_idx] <= wr_data;
                end
                if (upd_acc && upd_ok) begin
                    mem[upd_idx] <= upd_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w        <= '0;
            w_valid  <= 1'b0;
            sat_flag <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            w_valid <= rd_acc;
            if (rd_acc) begin
                w <= rd_ok ? mem[rd_idx] : '0;
            end
            if (upd_acc && upd_ok && upd_sat) begin
                sat_flag <= 1'b1;
            end
            if ((wr_acc && !wr_ok) || (upd_acc && !upd_ok) || (rd_acc && !rd_ok)) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_weight_bank.sv
module tb_weight_bank;

    localparam int D     = 16;
    localparam int S     = 3;
    localparam int R     = 3;
    localparam int L     = 5;
    localparam int LR    = 0;
    localparam int DEPTH = L * R;

    logic          clk = 1'b0;
    logic          reset, clear_req, busy;
    logic          wr_valid, wr_ready, upd_valid, upd_ready, rd_valid;
    logic [31:0]   wr_layer, wr_row, upd_layer, upd_row, rd_layer, rd_row;
    logic [D*S-1:0] wr_data, dc_dw, w;
    logic          w_valid, sat_flag, addr_err;

    always #5 clk = ~clk;

    weight_bank dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_layer(wr_layer),
        .wr_row(wr_row), .wr_data(wr_data),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_layer(upd_layer),
        .upd_row(upd_row), .dc_dw(dc_dw),
        .rd_valid(rd_valid), .rd_layer(rd_layer), .rd_row(rd_row),
        .w(w), .w_valid(w_valid), .sat_flag(sat_flag), .addr_err(addr_err)
    );

    // Reference model: plain integer weights; a clear simply zeroes everything
    // and blocks the ports for DEPTH cycles.
    int        mdl [L][R][S];
    int        clear_left;
    bit        known;
    logic [D*S-1:0] exp_w;
    bit        exp_wv, exp_sat, exp_ae;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [D*S-1:0] model_row(input int l, input int r);
        logic [D*S-1:0] v;
        v = '0;
        for (int i = 0; i < S; i++) v[(S-1-i)*D +: D] = D'(mdl[l][r][i]);
        return v;
    endfunction

    task automatic model_zero();
        for (int l = 0; l < L; l++)
            for (int r = 0; r < R; r++)
                for (int i = 0; i < S; i++) mdl[l][r][i] = 0;
    endtask

    task automatic idle_inputs();
        reset = 0; clear_req = 0;
        wr_valid = 0; wr_layer = 0; wr_row = 0; wr_data = '0;
        upd_valid = 0; upd_layer = 0; upd_row = 0; dc_dw = '0;
        rd_valid = 0; rd_layer = 0; rd_row = 0;
    endtask

    task automatic set_wr(input int l, input int r, input logic [D*S-1:0] d);
        wr_valid = 1; wr_layer = l; wr_row = r; wr_data = d;
    endtask

    task automatic set_upd(input int l, input int r, input logic [D*S-1:0] g);
        upd_valid = 1; upd_layer = l; upd_row = r; dc_dw = g;
    endtask

    task automatic set_rd(input int l, input int r);
        rd_valid = 1; rd_layer = l; rd_row = r;
    endtask

    // One clock: check handshakes against the model, advance the model with
    // the current inputs, take the edge, then check the registered outputs.
    task automatic cycle();
        bit idle, ok;
        int a, g, d;
        #1;
        idle = (clear_left == 0);
        if (known) begin
            check("busy", busy, !idle);
            check("wr_ready", wr_ready, idle);
            check("upd_ready", upd_ready, idle && !wr_valid);
        end
        if (reset) begin
            clear_left = DEPTH; model_zero();
            exp_w = '0; exp_wv = 0; exp_sat = 0; exp_ae = 0;
        end else if (!idle) begin
            clear_left--;
            exp_wv = 0;
        end else begin
            exp_wv = rd_valid;
            if (rd_valid) begin
                ok = (rd_layer < L) && (rd_row < R);
                exp_w = ok ? model_row(rd_layer, rd_row) : '0;
                if (!ok) exp_ae = 1;
            end
            if (wr_valid) begin
                ok = (wr_layer < L) && (wr_row < R);
                if (!ok) exp_ae = 1;
                else for (int i = 0; i < S; i++)
                    mdl[wr_layer][wr_row][i] = $signed(wr_data[(S-1-i)*D +: D]);
            end else if (upd_valid) begin
                ok = (upd_layer < L) && (upd_row < R);
                if (!ok) exp_ae = 1;
                else for (int i = 0; i < S; i++) begin
                    a = mdl[upd_layer][upd_row][i];
                    g = $signed(dc_dw[(S-1-i)*D +: D]);
                    d = a - (g >>> LR);
                    if (d > 32767) begin d = 32767; exp_sat = 1; end
                    if (d < -32768) begin d = -32768; exp_sat = 1; end
                    mdl[upd_layer][upd_row][i] = d;
                end
            end
            if (clear_req) begin
                clear_left = DEPTH;
                model_zero();
            end
        end
        @(posedge clk);
        #1;
        if (reset) known = 1;
        check("w_valid", w_valid, exp_wv);
        check("w", w, exp_w);
        check("sat_flag", sat_flag, exp_sat);
        check("addr_err", addr_err, exp_ae);
    endtask

    task automatic read_all();
        for (int l = 0; l < L; l++)
            for (int r = 0; r < R; r++) begin
                idle_inputs(); set_rd(l, r); cycle();
            end
        idle_inputs();
    endtask

    initial begin
        known = 0; clear_left = 0;
        exp_w = '0; exp_wv = 0; exp_sat = 0; exp_ae = 0;
        model_zero();
        idle_inputs();

        // Reset, full sweep, then a read of the last row.
        reset = 1; cycle(); reset = 0;
        repeat (DEPTH) cycle();
        set_rd(4, 2); cycle(); idle_inputs();
        check("rd_l4r2_zero", w, 48'h0);

        // Write with same-cycle read of that row, then read back.
        set_wr(1, 2, 48'h0100_FF00_0080); set_rd(1, 2); cycle(); idle_inputs();
        check("rd_during_wr_old", w, 48'h0);
        set_rd(1, 2); cycle(); idle_inputs();
        check("rd_after_wr", w, 48'h0100_FF00_0080);

        // Saturating update and a plain subtraction.
        set_wr(0, 0, 48'h7F00_0100_0000); cycle(); idle_inputs();
        set_upd(0, 0, 48'hF000_0080_0000); cycle(); idle_inputs();
        set_rd(0, 0); cycle(); idle_inputs();
        check("upd_sat_row", w, 48'h7FFF_0080_0000);
        check("sat_flag_set", sat_flag, 1'b1);

        // Write and update together: write wins, update retried next cycle.
        set_wr(2, 0, 48'h0011_0022_0033); set_upd(2, 1, 48'h0001_0002_FFFF); cycle();
        idle_inputs(); set_upd(2, 1, 48'h0001_0002_FFFF); cycle(); idle_inputs();
        set_rd(2, 1); cycle(); idle_inputs();
        check("upd_after_retry", w, 48'hFFFF_FFFE_0001);

        // Out-of-range write, then a clear with writes hammering the port.
        set_wr(5, 0, 48'h1234_5678_9ABC); cycle(); idle_inputs();
        check("addr_err_l5", addr_err, 1'b1);
        read_all();
        clear_req = 1; cycle(); idle_inputs();
        for (int k = 0; k < DEPTH; k++) begin
            set_wr(k % L, k % R, {$urandom, $urandom});
            set_rd(k % L, k % R);
            clear_req = 1;
            cycle();
            idle_inputs();
        end
        read_all();

        // Reset in the middle of a sweep restarts it.
        set_wr(3, 1, 48'h0AAA_0BBB_0CCC); cycle(); idle_inputs();
        clear_req = 1; cycle(); idle_inputs();
        repeat (5) cycle();
        reset = 1; cycle(); reset = 0;
        repeat (DEPTH) cycle();
        read_all();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            reset     = ($urandom_range(0, 299) == 0);
            clear_req = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 2) == 0)
                set_wr($urandom_range(0, 5), $urandom_range(0, 3), {$urandom, $urandom});
            if ($urandom_range(0, 1) == 0)
                set_upd($urandom_range(0, 5), $urandom_range(0, 3),
                        ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                        : {16'($signed(12'($urandom))), 16'($signed(12'($urandom))),
                           16'($signed(12'($urandom)))});
            if ($urandom_range(0, 1) == 0)
                set_rd($urandom_range(0, 5), $urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) rd_layer = $urandom;
            cycle();
        end
        idle_inputs();
        repeat (DEPTH) cycle();
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/weight_bank.md
WEIGHT_BANK -- requirements
Module: weight_bank

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DATA_SIZE, 16, signed fixed-point word width.
- FRAC_BITS, 8, fractional bits of each word.
- SIZE, 3, words per row.
- ROWS, 3, rows per layer.
- LAYER_SIZE, 5, number of layers.
- LR_SHIFT, 0, arithmetic right shift applied to the gradient before subtraction.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning). The design has one clock, clk; reset is synchronous and active-high, named reset.
- clk, in, 1, clock; all state changes on the rising edge.
- reset, in, 1, synchronous active-high reset.
- clear_req, in, 1, pulse that requests a zero sweep of all weights.
- busy, out, 1, high while a clear sweep is running.
- wr_valid, in, 1, write request.
- wr_ready, out, 1, write accepted when high together with wr_valid.
- wr_layer, in, 32, write layer index.
- wr_row, in, 32, write row index.
- wr_data, in, DATA_SIZE*SIZE, row data; word 0 is in the MSBs.
- upd_valid, in, 1, gradient-update request.
- upd_ready, out, 1, update accepted when high together with upd_valid.
- upd_layer, in, 32, update layer index.
- upd_row, in, 32, update row index.
- dc_dw, in, DATA_SIZE*SIZE, signed gradient row; word 0 is in the MSBs.
- rd_valid, in, 1, read request.
- rd_layer, in, 32, read layer index.
- rd_row, in, 32, read row index.
- w, out, DATA_SIZE*SIZE, registered read data.
- w_valid, out, 1, high for one cycle when w holds a read result.
- sat_flag, out, 1, sticky; set when any update saturates.
- addr_err, out, 1, sticky; set on any out-of-range accepted request.

Function
REQ-003 Storage SHALL hold LAYER_SIZE*ROWS rows of SIZE signed words.
REQ-004 The FSM SHALL have states IDLE and CLEAR; reset and clear_req (taken in IDLE) SHALL enter CLEAR.
REQ-005 In CLEAR, the block SHALL zero one row per cycle in ascending order: layer-major, then row.
- The sweep SHALL take exactly LAYER_SIZE*ROWS cycles, then return to IDLE.
- clear_req during CLEAR SHALL be ignored.
REQ-006 busy SHALL be 1 exactly while in CLEAR.
- wr_ready and upd_ready SHALL be 0 in CLEAR.
- Read requests in CLEAR SHALL be ignored: no w_valid.
REQ-007 In IDLE, wr_ready SHALL be 1, and upd_ready SHALL be the inverse of wr_valid, so a write has priority over an update.
REQ-008 An accepted write SHALL replace the addressed row with wr_data at the clock edge where it is accepted.
REQ-009 An accepted update SHALL set each word i as follows:
- Compute w_i - (dc_dw_i >>> LR_SHIFT) at DATA_SIZE+1 bits.
- Saturate the result to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
REQ-010 Any saturating word SHALL set sat_flag; sat_flag is cleared only by reset.
REQ-011 The read latency SHALL be 1 cycle:
- w and w_valid SHALL reflect the request sampled on the previous edge.
- The read SHALL return the pre-write contents when the same row is written or updated in the same cycle.
REQ-012 When rd_valid=0, w SHALL hold its last value and w_valid SHALL be 0.
REQ-013 An accepted request with layer >= LAYER_SIZE or row >= ROWS SHALL:
- not modify storage;
- return w = 0 if it is a read;
- set addr_err, which is cleared only by reset.
REQ-014 Writes, updates and reads accepted in the same IDLE cycle to different rows SHALL all take effect.

Reset
REQ-015 Reset SHALL force the following values:
- w=0, w_valid=0, sat_flag=0, addr_err=0;
- busy=1 from the next cycle, with a full CLEAR sweep;
- all weights SHALL read 0 after the sweep.
REQ-016 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from row 0 of layer 0 and discard pending requests.
REQ-017 After reset deasserts, busy SHALL fall exactly LAYER_SIZE*ROWS cycles later, which is 15 with the defaults.

Verification
REQ-018 The bench SHALL cover these directed scenarios (default parameters):
- Reset 1 cycle -> busy high 15 cycles; then read L4 R2 -> w=0, w_valid=1 one cycle later.
- Write L1 R2 {0x0100,0xFF00,0x0080}, then read -> the same value after 1 cycle; in the write cycle, a read of the same row returns the old 0.
- Update a row of 0x7F00 with dc_dw word 0xF000 (-16.0) -> saturates to 0x7FFF, sat_flag=1; 0x0100 minus 0x0080 -> 0x0080.
- wr_valid and upd_valid together -> upd_ready=0, only the write applied; the update is accepted the next cycle.
- Write to L5 -> storage unchanged, addr_err=1; clear_req after data is loaded -> 15-cycle sweep, all rows 0, and wr_ready=0 throughout.
